// File: rtl/can_reg_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// can_reg_pkg : register map, sequencer state type and bus-width defaults.
// Rev 1.0
// ---------------------------------------------------------------------------
package can_reg_pkg;

  localparam int c_addr_w_default = 8;
  localparam int c_data_w_default = 32;

  localparam logic [7:0] c_reg_errcnt  = 8'h10;
  localparam logic [7:0] c_reg_errstat = 8'h14;
  localparam logic [7:0] c_reg_status  = 8'h18;
  localparam logic [7:0] c_reg_isr     = 8'h1C;
  localparam logic [7:0] c_reg_rxid    = 8'h50;
  localparam logic [7:0] c_reg_rxdlc   = 8'h54;
  localparam logic [7:0] c_reg_rxdw1   = 8'h58;
  localparam logic [7:0] c_reg_rxdw2   = 8'h5C;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_GAP  = 2'd2
  } seq_state_t;

endpackage
`default_nettype wire

// File: rtl/can_rr_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// can_rr_arbiter : combinational round-robin pick, first request at or after ptr.
// Rev 1.0
// ---------------------------------------------------------------------------
module can_rr_arbiter #(
  parameter int NREQ = 3,
  parameter int ID_W = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [ID_W-1:0] ptr,
  output logic            any,
  output logic [NREQ-1:0] gnt_onehot,
  output logic [ID_W-1:0] gnt_idx
);

  logic [ID_W:0] w_cand;

  // Walk offsets from farthest to nearest so the nearest hit is the last write.
  always_comb begin
    any        = 1'b0;
    gnt_onehot = '0;
    gnt_idx    = '0;
    w_cand     = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      w_cand = {1'b0, ptr} + (ID_W + 1)'(k);
      if (w_cand >= (ID_W + 1)'(NREQ)) begin
        w_cand = w_cand - (ID_W + 1)'(NREQ);
      end
      if (req[w_cand[ID_W-1:0]]) begin
        any     = 1'b1;
        gnt_idx = w_cand[ID_W-1:0];
      end
    end
    if (any) begin
      gnt_onehot[gnt_idx] = 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/can_reg_read_sequencer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// can_reg_read_sequencer : shares the CAN register-read mux among requesters,
// issuing single or burst reads with ack timeout. Rev 1.0
// ---------------------------------------------------------------------------
module can_reg_read_sequencer
  import can_reg_pkg::*;
#(
  parameter int NREQ      = 3,
  parameter int BURST_LEN = 4,
  parameter int TIMEOUT   = 255,
  parameter int ADDR_W    = c_addr_w_default,
  parameter int DATA_W    = c_data_w_default
) (
  input  logic                      sys_clk,
  input  logic                      IP2Can_resetn,
  input  logic [NREQ-1:0]           req,
  input  logic [NREQ*ADDR_W-1:0]    req_addr,
  input  logic [NREQ-1:0]           req_burst,
  output logic                      Controller2MUX_CS,
  output logic [ADDR_W-1:0]         addr_bus1,
  input  logic                      MUX2Controller_ack,
  input  logic [DATA_W-1:0]         MUX2Can_data,
  output logic [NREQ-1:0]           gnt,
  output logic                      rd_valid,
  output logic [DATA_W-1:0]         rd_data,
  output logic [$clog2(NREQ)-1:0]   rd_id,
  output logic                      rd_last,
  output logic [NREQ-1:0]           done,
  output logic [NREQ-1:0]           err
);

  localparam int ID_W   = $clog2(NREQ);
  localparam int BEAT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam int TMR_W  = 10;

  localparam logic [TMR_W-1:0]  c_timer_last = TMR_W'(TIMEOUT - 1);
  localparam logic [BEAT_W-1:0] c_beat_last  = BEAT_W'(BURST_LEN - 1);
  localparam logic [ID_W-1:0]   c_idx_last   = ID_W'(NREQ - 1);

  seq_state_t        r_state;
  logic [ID_W-1:0]   r_ptr;
  logic [ID_W-1:0]   r_idx;
  logic [ADDR_W-1:0] r_start;
  logic              r_burst;
  logic              r_fin;
  logic [BEAT_W-1:0] r_beat;
  logic [TMR_W-1:0]  r_timer;

  logic              w_any;
  logic [NREQ-1:0]   w_onehot;
  logic [ID_W-1:0]   w_idx;
  logic [ADDR_W-1:0] w_req_addr;
  logic [ADDR_W-1:0] w_next_addr;
  logic              w_last_beat;

  can_rr_arbiter #(
    .NREQ (NREQ),
    .ID_W (ID_W)
  ) u_arb (
    .req        (req),
    .ptr        (r_ptr),
    .any        (w_any),
    .gnt_onehot (w_onehot),
    .gnt_idx    (w_idx)
  );

  assign w_req_addr  = req_addr[w_idx*ADDR_W +: ADDR_W];
  assign w_last_beat = !r_burst || (r_beat == c_beat_last);
  // Next beat address is start + 4*(beat+1); low two bits ride through untouched.
  assign w_next_addr = r_start + ADDR_W'({r_beat + 1'b1, 2'b00});

  always_ff @(posedge sys_clk or negedge IP2Can_resetn) begin
    if (!IP2Can_resetn) begin
      r_state           <= ST_IDLE;
      r_ptr             <= '0;
      r_idx             <= '0;
      r_start           <= '0;
      r_burst           <= 1'b0;
      r_fin             <= 1'b0;
      r_beat            <= '0;
      r_timer           <= '0;
      Controller2MUX_CS <= 1'b0;
      addr_bus1         <= '0;
      gnt               <= '0;
      rd_valid          <= 1'b0;
      rd_data           <= '0;
      rd_id             <= '0;
      rd_last           <= 1'b0;
      done              <= '0;
      err               <= '0;
    end else begin
      rd_valid <= 1'b0;
      rd_last  <= 1'b0;
      done     <= '0;
      err      <= '0;
      case (r_state)
        ST_IDLE: begin
          if (w_any) begin
            r_idx             <= w_idx;
            gnt               <= w_onehot;
            r_start           <= w_req_addr;
            addr_bus1         <= w_req_addr;
            r_burst           <= req_burst[w_idx];
            r_beat            <= '0;
            r_timer           <= '0;
            r_fin             <= 1'b0;
            Controller2MUX_CS <= 1'b1;
            r_state           <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (MUX2Controller_ack) begin
            rd_data           <= MUX2Can_data;
            rd_valid          <= 1'b1;
            rd_id             <= r_idx;
            Controller2MUX_CS <= 1'b0;
            r_timer           <= '0;
            r_fin             <= w_last_beat;
            if (w_last_beat) begin
              rd_last <= 1'b1;
              done    <= gnt;
            end
            r_state <= ST_GAP;
          end else if (r_timer == c_timer_last) begin
            Controller2MUX_CS <= 1'b0;
            err               <= gnt;
            r_fin             <= 1'b1;
            r_timer           <= '0;
            r_state           <= ST_GAP;
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end
        ST_GAP: begin
          if (!r_fin) begin
            r_beat            <= r_beat + 1'b1;
            addr_bus1         <= w_next_addr;
            Controller2MUX_CS <= 1'b1;
            r_state           <= ST_WAIT;
          end else begin
            gnt     <= '0;
            r_ptr   <= (r_idx == c_idx_last) ? '0 : r_idx + 1'b1;
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_can_reg_read_sequencer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_can_reg_read_sequencer : transaction-schedule model with per-cycle compare.
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_can_reg_read_sequencer;

  localparam int NREQ      = 3;
  localparam int BURST_LEN = 4;
  localparam int TIMEOUT   = 8;
  localparam int ADDR_W    = 8;
  localparam int DATA_W    = 32;

  logic                   sys_clk = 1'b0;
  logic                   IP2Can_resetn = 1'b0;
  logic [NREQ-1:0]        req = '0;
  logic [NREQ*ADDR_W-1:0] req_addr = '0;
  logic [NREQ-1:0]        req_burst = '0;
  logic                   cs;
  logic [ADDR_W-1:0]      addr_bus1;
  logic                   ack = 1'b0;
  logic [DATA_W-1:0]      mdata = '0;
  logic [NREQ-1:0]        gnt;
  logic                   rd_valid;
  logic [DATA_W-1:0]      rd_data;
  logic [1:0]             rd_id;
  logic                   rd_last;
  logic [NREQ-1:0]        done;
  logic [NREQ-1:0]        err;

  always #5 sys_clk = ~sys_clk;

  can_reg_read_sequencer #(
    .NREQ(NREQ), .BURST_LEN(BURST_LEN), .TIMEOUT(TIMEOUT), .ADDR_W(ADDR_W), .DATA_W(DATA_W)
  ) dut (
    .sys_clk(sys_clk), .IP2Can_resetn(IP2Can_resetn), .req(req), .req_addr(req_addr),
    .req_burst(req_burst), .Controller2MUX_CS(cs), .addr_bus1(addr_bus1),
    .MUX2Controller_ack(ack), .MUX2Can_data(mdata), .gnt(gnt), .rd_valid(rd_valid),
    .rd_data(rd_data), .rd_id(rd_id), .rd_last(rd_last), .done(done), .err(err)
  );

  // One record per clock cycle of expected DUT outputs plus what the mux must drive.
  typedef struct {
    logic        cs;
    logic [7:0]  addr;
    logic [2:0]  gnt;
    logic        rdv;
    logic [31:0] rdata;
    logic [1:0]  rid;
    logic        rlast;
    logic [2:0]  done;
    logic [2:0]  err;
    logic        ack;
    logic [31:0] adata;
    int          beat;
    bit          fin;
  } rec_t;

  rec_t        q[$];
  int          dq[$];
  logic [31:0] dataq[$];
  int          ptr;
  logic [7:0]  m_addr;
  logic [31:0] m_rd_data;
  logic [1:0]  m_rd_id;
  bit          auto_req, keep_req;
  int          n_checks, n_fail, tx_done, cur_beat;
  bit          cur_cs;

  logic [7:0]  addr_log[$];
  int          gnt_log[$];
  int          cs_high_cnt, rdv_cnt, rlast_cnt, done_cnt;
  logic [2:0]  done_acc, err_acc;
  logic [31:0] last_rdata;
  logic [1:0]  last_rid;
  logic        last_rlast, prev_cs;
  logic [2:0]  prev_gnt;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  function automatic rec_t mk(input logic c, input logic [7:0] a, input logic [2:0] g);
    rec_t r;
    r.cs = c; r.addr = a; r.gnt = g; r.rdv = 1'b0; r.rdata = m_rd_data; r.rid = m_rd_id;
    r.rlast = 1'b0; r.done = '0; r.err = '0; r.ack = 1'b0; r.adata = '0; r.beat = 0; r.fin = 1'b0;
    return r;
  endfunction

  function automatic int rand_delay();
    int r;
    r = int'($urandom_range(0, 19));
    if (r < 2) return 0;
    if (r < 4) return TIMEOUT;
    return int'($urandom_range(1, 5));
  endfunction

  // Plan a whole transaction: d CS-high cycles per beat (ack on the d-th, 0 = none),
  // then one CS-low cycle carrying the result pulses.
  task automatic build();
    int w, beats, d, n;
    logic [7:0] a;
    logic [2:0] oh;
    logic [31:0] dv;
    rec_t r;
    w = -1;
    for (int k = 0; k < NREQ; k++) begin
      int i;
      i = (ptr + k) % NREQ;
      if (w < 0 && req[i]) w = i;
    end
    oh = 3'(1 << w);
    beats = req_burst[w] ? BURST_LEN : 1;
    for (int b = 0; b < beats; b++) begin
      a  = req_addr[w*ADDR_W +: ADDR_W] + 8'(4 * b);
      d  = (dq.size() > 0) ? dq.pop_front() : rand_delay();
      dv = (dataq.size() > 0) ? dataq.pop_front() : $urandom;
      n  = (d == 0) ? TIMEOUT : d;
      m_addr = a;
      for (int k = 1; k <= n; k++) begin
        r = mk(1'b1, a, oh); r.beat = b; r.ack = (k == d); r.adata = dv;
        q.push_back(r);
      end
      if (d != 0) begin
        m_rd_data = dv; m_rd_id = 2'(w);
        r = mk(1'b0, a, oh); r.rdv = 1'b1; r.rlast = (b == beats - 1);
        r.done = r.rlast ? oh : 3'b000; r.fin = r.rlast; r.beat = b;
        q.push_back(r);
        if (r.rlast) break;
      end else begin
        r = mk(1'b0, a, oh); r.err = oh; r.fin = 1'b1; r.beat = b;
        q.push_back(r);
        break;
      end
    end
    ptr = (w + 1) % NREQ;
  endtask

  task automatic set_req(input int i, input logic [7:0] a, input logic b);
    req_addr[i*ADDR_W +: ADDR_W] = a;
    req_burst[i] = b;
    req[i] = 1'b1;
  endtask

  task automatic observe();
    if (cs && !prev_cs) addr_log.push_back(addr_bus1);
    if (cs) cs_high_cnt++;
    if (gnt != 0 && prev_gnt == 0) begin
      for (int k = 0; k < NREQ; k++) if (gnt[k]) gnt_log.push_back(k);
    end
    if (rd_valid) begin rdv_cnt++; last_rdata = rd_data; last_rid = rd_id; last_rlast = rd_last; end
    if (rd_last) rlast_cnt++;
    if (done != 0) done_cnt++;
    done_acc |= done; err_acc |= err;
    prev_cs = cs; prev_gnt = gnt;
  endtask

  task automatic clear_logs();
    addr_log.delete(); gnt_log.delete();
    cs_high_cnt = 0; rdv_cnt = 0; rlast_cnt = 0; done_cnt = 0;
    done_acc = '0; err_acc = '0; last_rdata = '0; last_rid = '0; last_rlast = 1'b0;
  endtask

  task automatic model_reset();
    q.delete(); dq.delete(); dataq.delete();
    ptr = 0; m_addr = '0; m_rd_data = '0; m_rd_id = '0;
    req = '0; ack = 1'b0; prev_cs = 1'b0; prev_gnt = '0;
  endtask

  task automatic step();
    rec_t e;
    @(negedge sys_clk);
    if (auto_req) begin
      for (int i = 0; i < NREQ; i++)
        if (!req[i] && $urandom_range(0, 3) == 0) set_req(i, 8'($urandom), 1'($urandom_range(0, 1)));
    end
    if (q.size() == 0) begin
      e = mk(1'b0, m_addr, 3'b000);
      if (req != '0) build();
    end else begin
      e = q.pop_front();
    end
    check("cycle", {cs, addr_bus1, gnt, rd_valid, rd_data, rd_id, rd_last, done, err},
          {e.cs, e.addr, e.gnt, e.rdv, e.rdata, e.rid, e.rlast, e.done, e.err});
    observe();
    cur_cs = e.cs;
    cur_beat = e.beat;
    if (e.fin) begin
      tx_done++;
      if (!keep_req) req &= ~(e.done | e.err);
    end
    if (auto_req && e.cs && $urandom_range(0, 49) == 0) req &= ~e.gnt;
    ack   = e.ack | (!e.cs && $urandom_range(0, 3) == 0);
    mdata = e.ack ? e.adata : $urandom;
  endtask

  task automatic run_tx(input int n, input int budget);
    int start, c;
    start = tx_done; c = 0;
    while (tx_done - start < n && c < budget) begin step(); c++; end
    if (tx_done - start < n) begin
      n_checks++; n_fail++;
      $display("FAIL run_tx: completed %0d of %0d transactions", tx_done - start, n);
    end
  endtask

  function automatic logic [31:0] pack_addr();
    logic [31:0] v;
    v = '1;
    for (int k = 0; k < 4; k++) if (k < addr_log.size()) v[31-8*k -: 8] = addr_log[k];
    return v;
  endfunction

  function automatic logic [15:0] pack_gnt();
    logic [15:0] v;
    v = '1;
    for (int k = 0; k < 4; k++) if (k < gnt_log.size()) v[15-4*k -: 4] = 4'(gnt_log[k]);
    return v;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks = 0; n_fail = 0; tx_done = 0; auto_req = 0; keep_req = 0; cur_beat = 0; cur_cs = 0;
    model_reset();
    clear_logs();
    repeat (3) @(posedge sys_clk);
    @(negedge sys_clk);
    check("reset_outputs", {cs, addr_bus1, gnt, rd_valid, rd_data, rd_id, rd_last, done, err}, 64'd0);
    @(posedge sys_clk); #1 IP2Can_resetn = 1'b1;

    // Single read
    clear_logs(); dq = '{4}; dataq = '{32'hA5A5_0001};
    set_req(0, 8'h18, 1'b0);
    run_tx(1, 50);
    check("t1_addr", pack_addr(), 32'h18FF_FFFF);
    check("t1_rdata", last_rdata, 32'hA5A5_0001);
    check("t1_rid", last_rid, 0);
    check("t1_rlast", {rlast_cnt[7:0], last_rlast}, {8'd1, 1'b1});
    check("t1_done", {done_acc, err_acc}, {3'b001, 3'b000});

    // Timeout on requester 1, then requester 2 served
    clear_logs(); dq = '{0, 2};
    set_req(1, 8'h1C, 1'b0); set_req(2, 8'h10, 1'b0);
    run_tx(2, 80);
    check("t4_gnt", pack_gnt(), 16'h12FF);
    check("t4_err", {err_acc, done_acc}, {3'b010, 3'b100});
    check("t4_rdv", rdv_cnt, 1);
    check("t4_cs_cycles", cs_high_cnt, 10);

    // Ack on the final allowed WAIT cycle
    clear_logs(); dq = '{TIMEOUT};
    set_req(0, 8'h14, 1'b0);
    run_tx(1, 50);
    check("t5_flags", {done_acc, err_acc}, {3'b001, 3'b000});
    check("t5_rdv", rdv_cnt, 1);
    check("t5_cs_cycles", cs_high_cnt, 8);

    // RX-FIFO burst
    clear_logs(); dq = '{1, 2, 1, 3};
    set_req(2, 8'h50, 1'b1);
    run_tx(1, 80);
    check("t2_addr", pack_addr(), 32'h5054_585C);
    check("t2_ncs", addr_log.size(), 4);
    check("t2_rdv", {rdv_cnt[7:0], rlast_cnt[7:0], last_rlast}, {8'd4, 8'd1, 1'b1});
    check("t2_done", {done_acc, done_cnt[7:0]}, {3'b100, 8'd1});

    // Round robin with all requesters held
    clear_logs(); dq = '{1, 1, 1, 1}; keep_req = 1;
    set_req(0, 8'h18, 1'b0); set_req(1, 8'h1C, 1'b0); set_req(2, 8'h10, 1'b0);
    run_tx(4, 80);
    keep_req = 0; req = '0;
    check("t3_gnt_order", pack_gnt(), 16'h0120);

    // Address wrap
    clear_logs(); dq = '{1, 1, 1, 1};
    set_req(0, 8'hFC, 1'b1);
    run_tx(1, 80);
    check("t6_wrap_addr", pack_addr(), 32'hFC00_0408);

    // Reset in the middle of beat 2 of a burst
    clear_logs(); dq = '{2, 6, 2, 2};
    set_req(1, 8'h50, 1'b1);
    for (int c = 0; c < 40 && !(cur_cs && cur_beat == 1); c++) step();
    check("t6_reached_beat2", {cur_cs, 8'(cur_beat)}, {1'b1, 8'd1});
    #2 IP2Can_resetn = 1'b0;
    model_reset();
    #1 check("t6_async_reset", {cs, addr_bus1, gnt, rd_valid, rd_data, rd_id, rd_last, done, err}, 64'd0);
    @(negedge sys_clk);
    check("t6_held_reset", {cs, addr_bus1, gnt, rd_valid, rd_data, rd_id, rd_last, done, err}, 64'd0);
    check("t6_no_done", {done_acc, err_acc}, 6'd0);
    @(posedge sys_clk); #1 IP2Can_resetn = 1'b1;
    clear_logs(); dq = '{1};
    set_req(0, 8'h18, 1'b0); set_req(1, 8'h1C, 1'b0); set_req(2, 8'h10, 1'b0);
    run_tx(1, 50);
    check("t6_first_gnt", pack_gnt(), 16'h0FFF);

    // Randomised traffic
    auto_req = 1;
    repeat (3000) step();
    auto_req = 0;
    begin
      int c;
      c = 0;
      while ((req != '0 || q.size() != 0) && c < 3000) begin step(); c++; end
      if (req != '0 || q.size() != 0) begin
        n_checks++; n_fail++;
        $display("FAIL drain: req=%0b pending=%0d", req, q.size());
      end
    end
    repeat (3) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
